// File: rtl/bp_update_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_scheduler_pkg
// Purpose  : Shared definitions for the branch-predictor update scheduler:
//            default widths, BHT counter encodings, BHT write-op codes,
//            scheduler state encoding and the tag-width derivation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bp_update_scheduler_pkg;

  localparam int c_WORD_SIZE_DEF = 16;
  localparam int c_IDX_W_DEF     = 4;
  localparam int c_QDEPTH_DEF    = 4;

  // 2-bit saturating BHT counter states held in the predictor storage.
  typedef enum logic [1:0] {
    BHT_STRONG_NT = 2'b00,
    BHT_WEAK_NT   = 2'b01,
    BHT_WEAK_T    = 2'b10,
    BHT_STRONG_T  = 2'b11
  } bht_state_e;

  // Operation the storage applies to the BHT entry at wr_idx.
  typedef enum logic [1:0] {
    BHT_OP_INIT   = 2'b00,  // initialise to StrongTaken
    BHT_OP_INC    = 2'b01,  // saturating increment (taken)
    BHT_OP_DEC    = 2'b10,  // saturating decrement (not taken)
    BHT_OP_SET_ST = 2'b11   // force StrongTaken (unconditional jump)
  } bht_op_e;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

  // Tag is everything above the table index bits.
  function automatic int tag_width(input int word_size, input int idx_w);
    return word_size - idx_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_req_fifo
// Purpose  : Small synchronous FIFO with synchronous clear. Pointers carry an
//            extra wrap bit so full and empty are distinguished without a
//            counter. A push while full is accepted only if a pop happens in
//            the same cycle.
// Ports    : clk, reset_n (sync, active-low)
//            i_clear  - empty the FIFO (wins over push/pop)
//            i_push   - write i_data
//            i_pop    - discard head entry
//            o_data   - head entry (valid when !o_empty)
//            o_empty, o_full - derived from registered pointers
// Revision : 1.0 - initial release
// ============================================================================
module bp_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule
`default_nettype wire

// File: rtl/bp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_scheduler
// Purpose  : Serialises all writes into the branch predictor tables (BTB
//            target, tag, 2-bit BHT) through their single write port. Sources
//            are ID-stage BTB installs, EX-stage BHT updates and an internal
//            init/flush sweep that rewrites every entry.
// Ports    : clk, reset_n (sync, active-low), flush_req (restart sweep)
//            id_valid/id_pc/id_target        - BTB install request
//            ex_valid/ex_pc/ex_is_jump/ex_taken - BHT update request
//            id_full/ex_full                 - request queue full flags
//            wr_en/wr_btb/wr_bht/wr_idx/wr_tag/wr_target/bht_op - registered
//                                              table write port
//            sweep_busy - tables invalid, fetch must not use predictions
//            drop_cnt   - saturating count of requests lost to full queues
// Revision : 1.0 - initial release
// ============================================================================
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = c_WORD_SIZE_DEF,
  parameter int IDX_W     = c_IDX_W_DEF,
  parameter int QDEPTH    = c_QDEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_req,
  input  logic                       id_valid,
  input  logic [WORD_SIZE-1:0]       id_pc,
  input  logic [WORD_SIZE-1:0]       id_target,
  input  logic                       ex_valid,
  input  logic [WORD_SIZE-1:0]       ex_pc,
  input  logic                       ex_is_jump,
  input  logic                       ex_taken,
  output logic                       id_full,
  output logic                       ex_full,
  output logic                       wr_en,
  output logic                       wr_btb,
  output logic                       wr_bht,
  output logic [IDX_W-1:0]           wr_idx,
  output logic [WORD_SIZE-IDX_W-1:0] wr_tag,
  output logic [WORD_SIZE-1:0]       wr_target,
  output logic [1:0]                 bht_op,
  output logic                       sweep_busy,
  output logic [7:0]                 drop_cnt
);

  localparam int TAG_W = tag_width(WORD_SIZE, IDX_W);
  localparam int ID_W  = IDX_W + TAG_W + WORD_SIZE;  // {idx, tag, target}
  localparam int EX_W  = IDX_W + 2;                  // {idx, op}
  localparam logic [IDX_W-1:0] c_LAST_IDX = '1;

  // --------------------------------------------------------------------------
  // State and registered write port
  // --------------------------------------------------------------------------
  sched_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_sweep_idx, w_sweep_idx_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic                 r_wr_btb, w_wr_btb_nxt;
  logic                 r_wr_bht, w_wr_bht_nxt;
  logic [IDX_W-1:0]     r_wr_idx, w_wr_idx_nxt;
  logic [TAG_W-1:0]     r_wr_tag, w_wr_tag_nxt;
  logic [WORD_SIZE-1:0] r_wr_target, w_wr_target_nxt;
  logic [1:0]           r_bht_op, w_bht_op_nxt;
  logic [7:0]           r_drop_cnt, w_drop_cnt_nxt;

  // --------------------------------------------------------------------------
  // Request queues
  // --------------------------------------------------------------------------
  logic            w_id_push, w_id_pop, w_id_empty, w_id_full, w_id_drop;
  logic            w_ex_push, w_ex_pop, w_ex_empty, w_ex_full, w_ex_drop;
  logic [ID_W-1:0] w_id_din, w_id_head;
  logic [EX_W-1:0] w_ex_din, w_ex_head;
  logic [1:0]      w_ex_op;

  logic [IDX_W-1:0]     w_id_h_idx;
  logic [TAG_W-1:0]     w_id_h_tag;
  logic [WORD_SIZE-1:0] w_id_h_tgt;
  logic [IDX_W-1:0]     w_ex_h_idx;
  logic [1:0]           w_ex_h_op;
  logic                 w_pick_id;
  logic                 w_unused_ex_hi;

  assign w_ex_op  = ex_is_jump ? BHT_OP_SET_ST :
                    (ex_taken ? BHT_OP_INC : BHT_OP_DEC);
  assign w_id_din = {id_pc[IDX_W-1:0], id_pc[WORD_SIZE-1:IDX_W], id_target};
  assign w_ex_din = {ex_pc[IDX_W-1:0], w_ex_op};

  // Only the index of a resolved PC matters to the BHT.
  assign w_unused_ex_hi = ^ex_pc[WORD_SIZE-1:IDX_W];

  assign w_id_h_idx = w_id_head[ID_W-1 -: IDX_W];
  assign w_id_h_tag = w_id_head[WORD_SIZE +: TAG_W];
  assign w_id_h_tgt = w_id_head[WORD_SIZE-1:0];
  assign w_ex_h_idx = w_ex_head[EX_W-1 -: IDX_W];
  assign w_ex_h_op  = w_ex_head[1:0];

  // A full queue still accepts when its head leaves in the same cycle.
  // Requests presented on a flush cycle are discarded, not counted.
  assign w_id_push = id_valid && !flush_req && (!w_id_full || w_id_pop);
  assign w_id_drop = id_valid && !flush_req && w_id_full && !w_id_pop;
  assign w_ex_push = ex_valid && !flush_req && (!w_ex_full || w_ex_pop);
  assign w_ex_drop = ex_valid && !flush_req && w_ex_full && !w_ex_pop;

  bp_req_fifo #(
    .WIDTH (ID_W),
    .DEPTH (QDEPTH)
  ) u_id_q (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (flush_req),
    .i_push  (w_id_push),
    .i_pop   (w_id_pop),
    .i_data  (w_id_din),
    .o_data  (w_id_head),
    .o_empty (w_id_empty),
    .o_full  (w_id_full)
  );

  bp_req_fifo #(
    .WIDTH (EX_W),
    .DEPTH (QDEPTH)
  ) u_ex_q (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (flush_req),
    .i_push  (w_ex_push),
    .i_pop   (w_ex_pop),
    .i_data  (w_ex_din),
    .o_data  (w_ex_head),
    .o_empty (w_ex_empty),
    .o_full  (w_ex_full)
  );

  // ID normally yields to EX; it only takes priority once its queue is
  // full, so installs are not starved into drops by a busy EX stream.
  assign w_pick_id = !w_id_empty && (w_ex_empty || w_id_full);

  // --------------------------------------------------------------------------
  // Next-state / next-write logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    w_wr_en_nxt     = 1'b0;
    w_wr_btb_nxt    = 1'b0;
    w_wr_bht_nxt    = 1'b0;
    w_wr_idx_nxt    = r_wr_idx;
    w_wr_tag_nxt    = r_wr_tag;
    w_wr_target_nxt = r_wr_target;
    w_bht_op_nxt    = r_bht_op;
    w_id_pop        = 1'b0;
    w_ex_pop        = 1'b0;

    if (flush_req) begin
      w_state_nxt     = ST_SWEEP;
      w_sweep_idx_nxt = '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          w_wr_en_nxt     = 1'b1;
          w_wr_btb_nxt    = 1'b1;
          w_wr_bht_nxt    = 1'b1;
          w_wr_idx_nxt    = r_sweep_idx;
          w_wr_tag_nxt    = '1;
          w_wr_target_nxt = '0;
          w_bht_op_nxt    = BHT_OP_INIT;
          w_sweep_idx_nxt = r_sweep_idx + 1'b1;
          if (r_sweep_idx == c_LAST_IDX) begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_RUN: begin
          if (!w_id_empty && !w_ex_empty && (w_id_h_idx == w_ex_h_idx)) begin
            // Same entry targeted by both sources: merge into one write.
            w_wr_en_nxt     = 1'b1;
            w_wr_btb_nxt    = 1'b1;
            w_wr_bht_nxt    = 1'b1;
            w_wr_idx_nxt    = w_id_h_idx;
            w_wr_tag_nxt    = w_id_h_tag;
            w_wr_target_nxt = w_id_h_tgt;
            w_bht_op_nxt    = w_ex_h_op;
            w_id_pop        = 1'b1;
            w_ex_pop        = 1'b1;
          end else if (w_pick_id) begin
            w_wr_en_nxt     = 1'b1;
            w_wr_btb_nxt    = 1'b1;
            w_wr_idx_nxt    = w_id_h_idx;
            w_wr_tag_nxt    = w_id_h_tag;
            w_wr_target_nxt = w_id_h_tgt;
            w_id_pop        = 1'b1;
          end else if (!w_ex_empty) begin
            w_wr_en_nxt  = 1'b1;
            w_wr_bht_nxt = 1'b1;
            w_wr_idx_nxt = w_ex_h_idx;
            w_bht_op_nxt = w_ex_h_op;
            w_ex_pop     = 1'b1;
          end
        end

        default: begin
          w_state_nxt     = ST_SWEEP;
          w_sweep_idx_nxt = '0;
        end
      endcase
    end
  end

  // Saturating drop counter; both sources may drop in the same cycle.
  logic [8:0] w_drop_sum;
  assign w_drop_sum     = {1'b0, r_drop_cnt} + {8'b0, w_id_drop} + {8'b0, w_ex_drop};
  assign w_drop_cnt_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
      r_wr_en     <= 1'b0;
      r_wr_btb    <= 1'b0;
      r_wr_bht    <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_tag    <= '0;
      r_wr_target <= '0;
      r_bht_op    <= 2'b00;
      r_drop_cnt  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_btb    <= w_wr_btb_nxt;
      r_wr_bht    <= w_wr_bht_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      r_wr_tag    <= w_wr_tag_nxt;
      r_wr_target <= w_wr_target_nxt;
      r_bht_op    <= w_bht_op_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
    end
  end

  assign id_full    = w_id_full;
  assign ex_full    = w_ex_full;
  assign wr_en      = r_wr_en;
  assign wr_btb     = r_wr_btb;
  assign wr_bht     = r_wr_bht;
  assign wr_idx     = r_wr_idx;
  assign wr_tag     = r_wr_tag;
  assign wr_target  = r_wr_target;
  assign bht_op     = r_bht_op;
  assign sweep_busy = (r_state == ST_SWEEP);
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
